// File: rtl/hex_event_reader_sparse_10.sv
// hex_event_reader_sparse_10
//   Reads back the sparse hex-event buffer built during a frame. Each 640-bit
//   memory word packs up to ten 64-bit hex records, and memory addresses count
//   records rather than words. After a start pulse, the block walks records
//   buffer_base .. buffer_base+event_count-1. It fetches one word per request
//   and streams one hex event per cycle to the rasterizer over valid/ready.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   start, abort          begin a pass (only from idle) / cancel a pass
//   buffer_base           first record address, sampled on start
//   event_count           number of records to read, sampled on start
//   mem_addr, mem_re      read request (record-granular address)
//   mem_ready             request accepted when mem_re && mem_ready
//   mem_rvalid, mem_rdata read response, one 640-bit word per accepted request
//   out_valid, out_ready  hex event stream handshake
//   out_q, out_r          signed axial coordinates (passed bit-exact)
//   out_depth             depth field
//   out_material          material field
//   busy                  pass in progress
//   done                  one-cycle pulse after the last record is accepted
module hex_event_reader_sparse_10 #(
    parameter int RECS_PER_WORD = 10,
    parameter int REC_W         = 64,
    parameter int ADDR_W        = 32,
    parameter int CNT_W         = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ADDR_W-1:0]              buffer_base,
    input  logic [CNT_W-1:0]               event_count,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           mem_re,
    input  logic                           mem_ready,
    input  logic                           mem_rvalid,
    input  logic [RECS_PER_WORD*REC_W-1:0] mem_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [15:0]                    out_q,
    output logic [15:0]                    out_r,
    output logic [7:0]                     out_depth,
    output logic [7:0]                     out_material,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W  = $clog2(RECS_PER_WORD + 1);
    localparam int WORD_W = RECS_PER_WORD * REC_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [IDX_W-1:0]    n_q, n_d;          // valid records in the current word
    logic [IDX_W-1:0]    k_q, k_d;          // record currently presented
    logic [WORD_W-1:0]   word_q, word_d;
    logic [REC_W-1:0]    out_rec_q, out_rec_d;

    logic [REC_W-1:0]    word_recs [RECS_PER_WORD];
    logic [IDX_W-1:0]    k_inc;
    logic                last_in_word;
    logic                unused_reserved;

    // Split the latched word into its record slots.
    genvar gi;
    generate
        for (gi = 0; gi < RECS_PER_WORD; gi++) begin : g_rec
            assign word_recs[gi] = word_q[gi*REC_W +: REC_W];
        end
    endgenerate

    assign k_inc        = k_q + IDX_W'(1);
    assign last_in_word = (k_q == n_q - IDX_W'(1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        n_d         = n_q;
        k_d         = k_q;
        word_d      = word_q;
        out_rec_d   = out_rec_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = buffer_base;
                    remaining_d = event_count;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // An empty pass goes straight to DONE from here, so busy is
                // seen for one cycle and no read is ever issued.
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else if (mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    word_d    = mem_rdata;
                    out_rec_d = mem_rdata[REC_W-1:0];
                    k_d       = '0;
                    n_d       = (remaining_q >= CNT_W'(RECS_PER_WORD))
                                ? IDX_W'(RECS_PER_WORD)
                                : remaining_q[IDX_W-1:0];
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (last_in_word) begin
                        remaining_d = remaining_q - CNT_W'(n_q);
                        addr_d      = addr_q + ADDR_W'(n_q);
                        state_d     = (remaining_q == CNT_W'(n_q)) ? S_DONE : S_REQ;
                    end else begin
                        k_d       = k_inc;
                        out_rec_d = word_recs[k_inc];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            n_q         <= '0;
            k_q         <= '0;
            word_q      <= '0;
            out_rec_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            n_q         <= n_d;
            k_q         <= k_d;
            word_q      <= word_d;
            out_rec_q   <= out_rec_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_re       = (state_q == S_REQ) && (remaining_q != '0);
    assign out_valid    = (state_q == S_DRAIN);
    assign busy         = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);

    assign out_q        = out_rec_q[63:48];
    assign out_r        = out_rec_q[47:32];
    assign out_depth    = out_rec_q[31:24];
    assign out_material = out_rec_q[23:16];

    // The low 16 bits of each record are reserved and intentionally dropped.
    assign unused_reserved = ^out_rec_q[15:0];

endmodule

// File: tb/tb_hex_event_reader_sparse_10.sv
module tb_hex_event_reader_sparse_10;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [31:0]  buffer_base;
    logic [15:0]  event_count;
    logic [31:0]  mem_addr;
    logic         mem_re, mem_ready, mem_rvalid;
    logic [639:0] mem_rdata;
    logic         out_valid, out_ready;
    logic [15:0]  out_q, out_r;
    logic [7:0]   out_depth, out_material;
    logic         busy, done;

    hex_event_reader_sparse_10 dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .buffer_base(buffer_base), .event_count(event_count),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_depth(out_depth), .out_material(out_material),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_at = -1;
    int mem_lat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: explicit overrides, otherwise a pattern derived from the address.
    logic [63:0] over_mem [int unsigned];

    function automatic logic [63:0] rec_of(input int unsigned a);
        logic [31:0] av;
        av = a;
        if (over_mem.exists(a)) return over_mem[a];
        return {av[15:0] + 16'h1234, ~av[15:0], av[7:0] ^ 8'h5A, av[15:8] + 8'd1, av[15:0]};
    endfunction

    // Behavioural model: the ordered event fields and word addresses a pass must produce.
    logic [47:0]  exp_ev[$];
    int unsigned  exp_addr[$];
    logic [47:0]  got_ev[$];
    int unsigned  got_addr[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic begin_pass(input int unsigned base, input int count);
        logic [63:0] r;
        for (int i = 0; i < count; i++) begin
            r = rec_of(base + i);
            exp_ev.push_back(r[63:16]);
        end
        for (int j = 0; j < count; j += 10) exp_addr.push_back(base + j);
        if (count == 0) done_at = cyc + 2;
        buffer_base = base;
        event_count = 16'(count);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        $display("pass base=%0h count=%0d started", base, count);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: done=%0b required 1 within %0d cycles", done, budget);
        end
        @(posedge clk); #1;
    endtask

    // Memory responder: one data beat mem_lat cycles after each accepted request.
    initial begin : mem_proc
        int unsigned a;
        logic [639:0] w;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_re && mem_ready) begin
                a = mem_addr;
                got_addr.push_back(a);
                $display("read addr=%0h", a);
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_addr: got read at %0h required none", a);
                end else begin
                    chk("mem_addr", a, exp_addr.pop_front());
                end
                for (int k = 0; k < 10; k++) w[k*64 +: 64] = rec_of(a + k);
                @(posedge clk);
                repeat (mem_lat - 1) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = w;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
        end
    end

    // Compare process: events, done timing and handshake stability every cycle.
    initial begin : cmp_proc
        logic [47:0] cur, prev_out;
        logic [31:0] prev_addr;
        logic        prev_stall, prev_req_stall;
        prev_stall = 1'b0;
        prev_req_stall = 1'b0;
        prev_out = '0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            cur = {out_q, out_r, out_depth, out_material};
            if (reset) begin
                prev_stall = 1'b0;
                prev_req_stall = 1'b0;
            end else begin
                chk("done", done, (cyc == done_at));
                if (done) chk("busy_in_done", busy, 1'b0);
                if (out_valid) begin
                    if (prev_stall) chk("stall_hold", cur, prev_out);
                    if (out_ready) begin
                        got_ev.push_back(cur);
                        $display("event q=%0h r=%0h d=%0h m=%0h", out_q, out_r, out_depth, out_material);
                        if (exp_ev.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL event: got extra %0h required none", cur);
                        end else begin
                            chk("event", cur, exp_ev.pop_front());
                            if (exp_ev.size() == 0) done_at = cyc + 1;
                        end
                    end
                end
                if (prev_req_stall) begin
                    chk("re_hold", mem_re, 1'b1);
                    chk("addr_hold", mem_addr, prev_addr);
                end
                prev_stall     = out_valid && !out_ready;
                prev_out       = cur;
                prev_req_stall = mem_re && !mem_ready;
                prev_addr      = mem_addr;
            end
        end
    end

    initial begin : stim
        int t;
        int busy_cnt, done_cnt;
        logic held;
        int unsigned tbl_base [4];
        int          tbl_cnt  [4];

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        buffer_base = '0; event_count = '0;
        mem_ready = 1'b1; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_data", {out_q, out_r, out_depth, out_material}, 48'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // T1: three records from one word with signed fields
        over_mem[32'h100] = {16'h0001, 16'hFFFF, 8'd5, 8'd7, 16'hDEAD};
        over_mem[32'h101] = {16'h0002, 16'hFFFE, 8'd6, 8'd7, 16'h0000};
        over_mem[32'h102] = {16'hFFFD, 16'h0003, 8'd9, 8'd7, 16'hFFFF};
        got_ev.delete(); got_addr.delete();
        begin_pass(32'h100, 3);
        wait_done(100);
        chk("t1_nev", got_ev.size(), 3);
        chk("t1_ev0", got_ev[0], 48'h0001_FFFF_05_07);
        chk("t1_ev1", got_ev[1], 48'h0002_FFFE_06_07);
        chk("t1_ev2", got_ev[2], 48'hFFFD_0003_09_07);
        chk("t1_nreads", got_addr.size(), 1);
        chk("t1_read0", got_addr[0], 32'h100);

        // T2: 23 records over three words, longer memory latency
        mem_lat = 3;
        got_ev.delete(); got_addr.delete();
        begin_pass(32'h40, 23);
        wait_done(300);
        chk("t2_nev", got_ev.size(), 23);
        chk("t2_nreads", got_addr.size(), 3);
        chk("t2_read0", got_addr[0], 32'h40);
        chk("t2_read1", got_addr[1], 32'h4A);
        chk("t2_read2", got_addr[2], 32'h54);
        mem_lat = 1;

        // T3: out_ready toggling, held low 5 cycles while record 4 is presented
        got_ev.delete(); got_addr.delete();
        out_ready = 1'b0;
        begin_pass(32'h300, 12);
        t = 0; held = 1'b0;
        while (!done && t < 400) begin
            if (!held && got_ev.size() == 4 && out_valid) begin
                out_ready = 1'b0;
                held = 1'b1;
                repeat (5) @(posedge clk);
                #1;
            end else begin
                out_ready = (t % 2 == 0);
                t++;
                @(posedge clk); #1;
            end
        end
        chk("t3_done_seen", done, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        chk("t3_nev", got_ev.size(), 12);

        // T4: memory stalls the request for 4 cycles
        got_ev.delete(); got_addr.delete();
        mem_ready = 1'b0;
        begin_pass(32'h500, 5);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_re_held", mem_re, 1'b1);
        chk("t4_addr_held", mem_addr, 32'h500);
        mem_ready = 1'b1;
        wait_done(100);
        chk("t4_nreads", got_addr.size(), 1);
        chk("t4_nev", got_ev.size(), 5);

        // T5: empty pass
        got_ev.delete(); got_addr.delete();
        begin_pass(32'h0, 0);
        busy_cnt = 0; done_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        chk("t5_busy_cycles", busy_cnt, 1);
        chk("t5_done_cycles", done_cnt, 1);
        chk("t5_nreads", got_addr.size(), 0);
        @(posedge clk); #1;

        // T6: abort at k=2, stale rvalid, abort+start together, then a fresh pass
        got_ev.delete(); got_addr.delete();
        begin_pass(32'h600, 8);
        t = 0;
        while (got_ev.size() < 2 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b0;
        abort = 1'b1;
        exp_ev.delete(); exp_addr.delete(); done_at = -1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t6_abort_valid", out_valid, 1'b0);
        chk("t6_abort_busy", busy, 1'b0);
        chk("t6_abort_re", mem_re, 1'b0);
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        mem_rdata = '1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("t6_stale_ignored", out_valid, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1; buffer_base = 32'h999; event_count = 16'd4;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("t6_abort_wins_busy", busy, 1'b0);
        chk("t6_abort_wins_re", mem_re, 1'b0);
        @(posedge clk); #1;
        got_ev.delete(); got_addr.delete();
        out_ready = 1'b1;
        begin_pass(32'h200, 1);
        wait_done(100);
        chk("t6_nev", got_ev.size(), 1);
        chk("t6_ev0", got_ev[0], 48'h1434_FDFF_5A_03);
        chk("t6_read0", got_addr[0], 32'h200);

        // Table of boundary passes: exact word, address wrap, single record
        tbl_base[0] = 32'h800;      tbl_cnt[0] = 10;
        tbl_base[1] = 32'hFFFFFFFC; tbl_cnt[1] = 12;
        tbl_base[2] = 32'h900;      tbl_cnt[2] = 1;
        tbl_base[3] = 32'hA00;      tbl_cnt[3] = 20;
        for (int i = 0; i < 4; i++) begin
            got_ev.delete();
            begin_pass(tbl_base[i], tbl_cnt[i]);
            wait_done(200);
            chk("tbl_nev", got_ev.size(), tbl_cnt[i]);
            chk("tbl_drained", exp_ev.size() + exp_addr.size(), 0);
        end

        // Reset in the middle of a pass
        begin_pass(32'h700, 15);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        reset = 1'b1;
        exp_ev.delete(); exp_addr.delete(); done_at = -1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_re", mem_re, 1'b0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_data", {out_q, out_r, out_depth, out_material}, 48'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        got_ev.delete();
        begin_pass(32'h7F0, 2);
        wait_done(100);
        chk("post_rst_nev", got_ev.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
